// File: rtl/lsu_hs_if.sv
// Request/response handshake bundle between the core data port and lsu_hs.
// Signal suffixes are from the load-store unit's point of view.
interface lsu_hs_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] addr_i;
    logic [31:0] st_data_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] ld_data_o;
    logic        rsp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_funct3_i, addr_i, st_data_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, ld_data_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_funct3_i, addr_i, st_data_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, ld_data_o, rsp_err_o
    );
endinterface

// File: rtl/lsu_hs.sv
// Handshaked load-store unit: data RAM, output registers and synchronised
// input channels in one 4 KiB window, with a one-entry registered response.
module lsu_hs #(
    parameter int DMEM_WORDS  = 512,
    parameter int OUT_CH      = 11,
    parameter int IN_CH       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    lsu_hs_if.slave               bus,
    input  logic [IN_CH*32-1:0]   io_in_i,
    output logic [OUT_CH*32-1:0]  io_out_o
);
    localparam int AW = $clog2(DMEM_WORDS);
    localparam int IW = IN_CH * 32;

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t r_state, w_stateNext;

    logic [11:0]        w_addr;
    logic [5:0]         w_idx;
    logic [AW-1:0]      w_ramIdx;
    logic               w_isRam, w_isOut, w_isIn;
    logic               w_accept, w_fault, w_doWrite, w_ramWe, w_statusClr;
    logic [3:0]         w_mask;
    logic [31:0]        w_wdata, w_rdWord, w_ext, w_ldNext;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [IN_CH-1:0]   w_change;

    logic [31:0]        r_mem [DMEM_WORDS];
    logic [31:0]        r_out [OUT_CH];
    logic [IW-1:0]      r_sync [SYNC_STAGES];
    logic [IW-1:0]      r_prev;
    logic [IN_CH-1:0]   r_flag;
    logic [31:0]        r_ldData;
    logic               r_err;

    assign w_addr   = bus.addr_i[11:0];
    assign w_idx    = w_addr[7:2];
    assign w_ramIdx = w_addr[AW+1:2];
    assign w_isRam  = !w_addr[11];
    assign w_isOut  = w_addr[11] && !w_addr[8];
    assign w_isIn   = w_addr[11] && w_addr[8];

    // Ready depends only on registered state and rsp_ready, never on req_valid.
    assign bus.req_ready_o = (r_state == S_EMPTY) || bus.rsp_ready_i;
    assign w_accept        = bus.req_valid_i && bus.req_ready_o;
    assign bus.rsp_valid_o = (r_state == S_FULL);
    assign bus.ld_data_o   = r_ldData;
    assign bus.rsp_err_o   = r_err;

    always_comb begin
        w_fault = 1'b0;
        case (bus.req_funct3_i)
            3'b000:  w_fault = 1'b0;
            3'b001:  w_fault = w_addr[0];
            3'b010:  w_fault = |w_addr[1:0];
            3'b100:  w_fault = bus.req_we_i;
            3'b101:  w_fault = bus.req_we_i | w_addr[0];
            default: w_fault = 1'b1;
        endcase
    end

    always_comb begin
        w_mask  = 4'b1111;
        w_wdata = bus.st_data_i;
        case (bus.req_funct3_i[1:0])
            2'b00: begin
                w_mask  = 4'b0001 << w_addr[1:0];
                w_wdata = {4{bus.st_data_i[7:0]}};
            end
            2'b01: begin
                w_mask  = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.st_data_i[15:0]}};
            end
            default: begin
                w_mask  = 4'b1111;
                w_wdata = bus.st_data_i;
            end
        endcase
    end

    assign w_doWrite   = w_accept && bus.req_we_i && !w_fault;
    assign w_ramWe     = w_doWrite && w_isRam;
    assign w_statusClr = w_accept && !bus.req_we_i && !w_fault && w_isIn && (w_idx == 6'd63);

    // RAM has no reset so it can map onto block RAM.
    always_ff @(posedge clk_i) begin
        if (w_ramWe) begin
            for (int b = 0; b < 4; b++) begin
                if (w_mask[b]) r_mem[w_ramIdx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < OUT_CH; k++) r_out[k] <= '0;
        end else if (w_doWrite && w_isOut) begin
            for (int k = 0; k < OUT_CH; k++) begin
                if (w_idx == 6'(k)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_mask[b]) r_out[k][8*b +: 8] <= w_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        io_out_o = '0;
        for (int k = 0; k < OUT_CH; k++) io_out_o[32*k +: 32] = r_out[k];
    end

    always_comb begin
        w_change = '0;
        for (int k = 0; k < IN_CH; k++)
            w_change[k] = |(r_sync[SYNC_STAGES-1][32*k +: 32] ^ r_prev[32*k +: 32]);
    end

    // A change seen on the clearing edge re-sets the flag, so no event is lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
            r_prev <= '0;
            r_flag <= '0;
        end else begin
            r_sync[0] <= io_in_i;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
            r_prev <= r_sync[SYNC_STAGES-1];
            r_flag <= w_change | (r_flag & {IN_CH{!w_statusClr}});
        end
    end

    always_comb begin
        w_rdWord = '0;
        if (w_isRam) begin
            w_rdWord = r_mem[w_ramIdx];
        end else if (w_isOut) begin
            for (int k = 0; k < OUT_CH; k++)
                if (w_idx == 6'(k)) w_rdWord = r_out[k];
        end else begin
            for (int k = 0; k < IN_CH; k++)
                if (w_idx == 6'(k)) w_rdWord = r_sync[SYNC_STAGES-1][32*k +: 32];
            if (w_idx == 6'd63) w_rdWord[IN_CH-1:0] = r_flag;
        end
    end

    always_comb begin
        w_byte = w_rdWord[7:0];
        case (w_addr[1:0])
            2'd0:    w_byte = w_rdWord[7:0];
            2'd1:    w_byte = w_rdWord[15:8];
            2'd2:    w_byte = w_rdWord[23:16];
            default: w_byte = w_rdWord[31:24];
        endcase
        w_half = w_addr[1] ? w_rdWord[31:16] : w_rdWord[15:0];
        w_ext  = '0;
        case (bus.req_funct3_i)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b010:  w_ext = w_rdWord;
            3'b100:  w_ext = {24'b0, w_byte};
            3'b101:  w_ext = {16'b0, w_half};
            default: w_ext = '0;
        endcase
        w_ldNext = (bus.req_we_i || w_fault) ? 32'b0 : w_ext;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ldData <= '0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_ldData <= w_ldNext;
            r_err    <= w_fault;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_EMPTY;
        else         r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_stateNext = S_FULL;
            S_FULL:  if (!w_accept && bus.rsp_ready_i) w_stateNext = S_EMPTY;
            default: w_stateNext = S_EMPTY;
        endcase
    end
endmodule

// File: tb/tb_lsu_hs.sv
// Randomised scoreboard bench for lsu_hs: a byte-level reference model predicts
// each response when a request is accepted; a monitor compares on handshake.
module tb_lsu_hs;
    localparam int DMEM_WORDS  = 512;
    localparam int OUT_CH      = 11;
    localparam int IN_CH       = 2;
    localparam int SYNC_STAGES = 2;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic [IN_CH*32-1:0]  ioIn;
    logic [OUT_CH*32-1:0] ioOut;

    lsu_hs_if bus();

    lsu_hs #(
        .DMEM_WORDS(DMEM_WORDS), .OUT_CH(OUT_CH), .IN_CH(IN_CH), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk_i(clk), .rst_ni(rstN), .bus(bus), .io_in_i(ioIn), .io_out_o(ioOut)
    );

    always #5 clk = ~clk;

    rsp_t expQ[$];
    rsp_t monExp;
    rsp_t dummy, bp1;
    int errors = 0;
    int checks = 0;
    int readyMode = 0;

    logic [7:0]       mdlMem [DMEM_WORDS*4];
    logic [7:0]       mdlOut [OUT_CH*4];
    logic [31:0]      mdlIn  [IN_CH];
    logic [IN_CH-1:0] mdlFlag;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic isFault(logic we, logic [2:0] f3, int a);
        case (f3)
            3'd0:    return 1'b0;
            3'd1:    return (a % 2) != 0;
            3'd2:    return (a % 4) != 0;
            3'd4:    return we;
            3'd5:    return we || ((a % 2) != 0);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [7:0] getByte(int a);
        int k;
        logic [31:0] w;
        k = (a / 4) % 64;
        w = '0;
        if (a < 2048) return mdlMem[a % (DMEM_WORDS*4)];
        if ((a & 'h100) == 0) return (k < OUT_CH) ? mdlOut[k*4 + a%4] : 8'h00;
        if (k < IN_CH) w = mdlIn[k];
        else if (k == 63) w = 32'(mdlFlag);
        return w[8*(a%4) +: 8];
    endfunction

    function automatic void putByte(int a, logic [7:0] v);
        int k;
        k = (a / 4) % 64;
        if (a < 2048) mdlMem[a % (DMEM_WORDS*4)] = v;
        else if (((a & 'h100) == 0) && k < OUT_CH) mdlOut[k*4 + a%4] = v;
    endfunction

    function automatic rsp_t modelAccess(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] st);
        rsp_t r;
        int a, n, base;
        logic [31:0] v;
        r = '0;
        a = int'(addr[11:0]);
        if (isFault(we, f3, a)) begin
            r.err = 1'b1;
            return r;
        end
        n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        base = a - (a % n);
        if (we) begin
            for (int i = 0; i < n; i++) putByte(base + i, 8'(st >> (8*i)));
            return r;
        end
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(getByte(base + i)) << (8*i));
        if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
        if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
        if (a >= 'h900 && ((a & 'h100) != 0) && ((a / 4) % 64) == 63) mdlFlag = '0;
        r.data = v;
        return r;
    endfunction

    function automatic logic [OUT_CH*32-1:0] modelOutVec();
        logic [OUT_CH*32-1:0] v;
        v = '0;
        for (int i = 0; i < OUT_CH*4; i++) v[8*i +: 8] = mdlOut[i];
        return v;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] data, output rsp_t exp);
        bit done;
        done = 0;
        exp = '0;
        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = we;
        bus.req_funct3_i = f3;
        bus.addr_i       = addr;
        bus.st_data_i    = data;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (bus.req_ready_o) begin
                exp = modelAccess(we, f3, addr, data);
                expQ.push_back(exp);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid_i = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL acceptTimeout: req_ready never high for addr 0x%08h, expected accept", addr);
        end
    endtask

    task automatic drainQueue();
        for (int c = 0; c < 300 && expQ.size() != 0; c++) @(posedge clk);
        #1;
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    endtask

    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       bus.rsp_ready_i = 1'b1;
            1:       bus.rsp_ready_i = 1'($urandom_range(0, 1));
            default: bus.rsp_ready_i = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (rstN && bus.rsp_valid_o && bus.rsp_ready_i) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedRsp: got data 0x%08h with no request outstanding", bus.ld_data_o);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("rspData", bus.ld_data_o, monExp.data);
                checkOutput("rspErr", 32'(bus.rsp_err_o), 32'(monExp.err));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] addr;
        logic [2:0]  f3;
        int          r;
        logic [2:0]  f3Tab [8];
        f3Tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

        bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_funct3_i = '0;
        bus.addr_i = '0; bus.st_data_i = '0; bus.rsp_ready_i = 1'b1;
        ioIn = '0;
        for (int i = 0; i < OUT_CH*4; i++) mdlOut[i] = 8'h00;
        for (int i = 0; i < DMEM_WORDS*4; i++) mdlMem[i] = 8'h00;
        for (int k = 0; k < IN_CH; k++) mdlIn[k] = '0;
        mdlFlag = '0;

        repeat (3) @(posedge clk);
        #3 rstN = 1'b1;
        @(negedge clk);
        checkOutput("resetRspValid", 32'(bus.rsp_valid_o), 32'd0);
        checkOutput("resetReqReady", 32'(bus.req_ready_o), 32'd1);
        checkOutput("resetLdData", bus.ld_data_o, 32'd0);
        checkOutput("resetErr", 32'(bus.rsp_err_o), 32'd0);
        checkOutput("resetIoOut", 32'(ioOut != '0), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < DMEM_WORDS; i++) applyStimulus(1'b1, 3'd2, 32'(i*4), $urandom(), dummy);

        $display("[TB] directed RAM accesses");
        applyStimulus(1'b1, 3'd2, 32'h010, 32'h1234_5678, dummy);
        applyStimulus(1'b0, 3'd2, 32'h010, 32'h0, dummy);
        applyStimulus(1'b1, 3'd0, 32'h013, 32'h0000_0080, dummy);
        applyStimulus(1'b0, 3'd0, 32'h013, 32'h0, dummy);
        applyStimulus(1'b0, 3'd4, 32'h013, 32'h0, dummy);
        applyStimulus(1'b1, 3'd1, 32'h012, 32'h0000_BEEF, dummy);
        applyStimulus(1'b0, 3'd5, 32'h012, 32'h0, dummy);
        applyStimulus(1'b0, 3'd1, 32'h012, 32'h0, dummy);
        applyStimulus(1'b0, 3'd2, 32'h002, 32'h0, dummy);
        applyStimulus(1'b1, 3'd1, 32'h011, 32'h0000_FFFF, dummy);
        applyStimulus(1'b0, 3'd2, 32'h010, 32'h0, dummy);
        applyStimulus(1'b0, 3'd3, 32'h010, 32'h0, dummy);
        applyStimulus(1'b1, 3'd4, 32'h010, 32'hFFFF_FFFF, dummy);
        applyStimulus(1'b1, 3'd2, 32'h900, 32'hFFFF_FFFF, dummy);
        applyStimulus(1'b0, 3'd2, 32'hABCD_E010, 32'h0, dummy);

        $display("[TB] output registers");
        applyStimulus(1'b1, 3'd2, 32'h804, 32'h0000_00A5, dummy);
        checkOutput("ioOutCh1", ioOut[63:32], 32'h0000_00A5);
        applyStimulus(1'b1, 3'd2, 32'(32'h800 + 4*OUT_CH), 32'hFFFF_FFFF, dummy);
        applyStimulus(1'b0, 3'd2, 32'(32'h800 + 4*OUT_CH), 32'h0, dummy);
        checkOutput("ioOutUnchanged", 32'(ioOut != modelOutVec()), 32'd0);
        drainQueue();

        $display("[TB] backpressure");
        readyMode = 2;
        repeat (2) @(posedge clk); #1;
        applyStimulus(1'b0, 3'd2, 32'h010, 32'h0, bp1);
        fork
            applyStimulus(1'b0, 3'd2, 32'h014, 32'h0, dummy);
            begin
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("bpReqReady", 32'(bus.req_ready_o), 32'd0);
                    checkOutput("bpRspValid", 32'(bus.rsp_valid_o), 32'd1);
                    checkOutput("bpHoldData", bus.ld_data_o, bp1.data);
                end
                readyMode = 0;
            end
        join
        drainQueue();

        $display("[TB] random traffic");
        readyMode = 1;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      addr = 32'($urandom_range(0, 2047));
            else if (r < 9) addr = 32'h800 | 32'($urandom_range(0, 255));
            else            addr = 32'h900 | 32'($urandom_range(0, 255));
            addr = addr | ($urandom() & 32'hFFFF_F000);
            r = $urandom_range(0, 9);
            f3 = (r < 8) ? f3Tab[r] : 3'd2;
            applyStimulus(1'($urandom_range(0, 1)), f3, addr, $urandom(), dummy);
        end
        readyMode = 0;
        drainQueue();
        for (int k = 0; k < OUT_CH; k++)
            checkOutput("ioOutRandom", ioOut[32*k +: 32], modelOutVec()[32*k +: 32]);

        $display("[TB] input synchronisers and change flags");
        ioIn[31:0] = 32'h5;
        applyStimulus(1'b0, 3'd2, 32'h900, 32'h0, dummy);
        repeat (3) @(posedge clk); #1;
        mdlIn[0] = 32'h5;
        mdlFlag[0] = 1'b1;
        applyStimulus(1'b0, 3'd2, 32'h900, 32'h0, dummy);
        applyStimulus(1'b0, 3'd2, 32'h904, 32'h0, dummy);
        applyStimulus(1'b0, 3'd2, 32'h908, 32'h0, dummy);
        applyStimulus(1'b0, 3'd2, 32'h9FC, 32'h0, dummy);
        applyStimulus(1'b0, 3'd2, 32'h9FC, 32'h0, dummy);
        ioIn[31:0] = 32'hA;
        repeat (2) @(posedge clk); #1;
        applyStimulus(1'b0, 3'd2, 32'h9FC, 32'h0, dummy);
        mdlIn[0] = 32'hA;
        mdlFlag[0] = 1'b1;
        applyStimulus(1'b0, 3'd2, 32'h9FC, 32'h0, dummy);
        applyStimulus(1'b0, 3'd2, 32'h900, 32'h0, dummy);
        drainQueue();

        $display("[TB] reset during pending response");
        ioIn = '0;
        readyMode = 2;
        repeat (4) @(posedge clk); #1;
        applyStimulus(1'b1, 3'd2, 32'h800, 32'hDEAD_BEEF, dummy);
        checkOutput("preResetIoOut", ioOut[31:0], 32'hDEAD_BEEF);
        checkOutput("preResetValid", 32'(bus.rsp_valid_o), 32'd1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("midResetValid", 32'(bus.rsp_valid_o), 32'd0);
        checkOutput("midResetIoOut", 32'(ioOut != '0), 32'd0);
        expQ.delete();
        for (int i = 0; i < OUT_CH*4; i++) mdlOut[i] = 8'h00;
        for (int k = 0; k < IN_CH; k++) mdlIn[k] = '0;
        mdlFlag = '0;
        readyMode = 0;
        repeat (2) @(posedge clk);
        #3 rstN = 1'b1;
        @(negedge clk);
        checkOutput("postResetReady", 32'(bus.req_ready_o), 32'd1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 3'd2, 32'h800, 32'h0, dummy);
        applyStimulus(1'b0, 3'd2, 32'h010, 32'h0, dummy);
        applyStimulus(1'b0, 3'd2, 32'h9FC, 32'h0, dummy);
        drainQueue();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu_hs.md
Name: lsu_hs

Overview:
- Parametrised, handshaked successor to the single-cycle load-store unit. It serves the core's data port with a valid/ready request channel and a registered valid/ready response channel.
- It maps a parametrised data RAM, OUT_CH output peripheral registers and IN_CH synchronised input channels into one 4 KiB window.
- It does RV32I sub-word access, sign/zero extension and misalignment detection, and provides clear-on-read change flags for the inputs.

Parameters:
- DMEM_WORDS, 512: data RAM depth in 32-bit words. Power of two, 2..512.
- OUT_CH, 11: number of 32-bit output peripheral registers, 1..63.
- IN_CH, 2: number of 32-bit input channels, 1..32.
- SYNC_STAGES, 2: synchroniser flops per input bit, 2..4.

Ports:
- clk_i, input, 1: clock.
- rst_ni, input, 1: reset, asynchronous, active-low.
- req_valid_i, input, 1: request valid.
- req_ready_o, output, 1: request ready.
- req_we_i, input, 1: 1 = store, 0 = load.
- req_funct3_i, input, 3: RV32I funct3. Loads: LB=000, LH=001, LW=010, LBU=100, LHU=101. Stores: SB=000, SH=001, SW=010.
- addr_i, input, 32: byte address.
- st_data_i, input, 32: store data, taken from the low bits.
- rsp_valid_o, output, 1: response valid.
- rsp_ready_i, input, 1: response ready.
- ld_data_o, output, 32: extended load data. Zero for stores and faults.
- rsp_err_o, output, 1: misaligned access or illegal funct3.
- io_in_i, input, IN_CH*32: asynchronous input channels. Channel k is bits [32k+31:32k].
- io_out_o, output, OUT_CH*32: output registers, packed the same way.

Behaviour:
- Address map, decoded on addr_i[11:0]. Upper bits are ignored.
  - addr[11]=0: data RAM. Word index is addr[log2(DMEM_WORDS)+1:2]; higher bits alias.
  - addr[11]=1, addr[8]=0: output register k = addr[7:2]. Index k >= OUT_CH reads 0 and ignores writes.
  - addr[11]=1, addr[8]=1: input channel k = addr[7:2] for k < IN_CH, returning the synchronised value. addr[7:2]=63 is the status word: bit k = change flag of channel k, other bits 0. Any other index reads 0.
- Handshake:
  - A request is accepted on a clock edge with req_valid_i && req_ready_o.
  - req_ready_o = !rsp_valid_o || rsp_ready_i. This is a one-entry response buffer with no combinational path from req_valid_i.
  - Every accepted request produces exactly one response. rsp_valid_o rises on the edge after acceptance.
  - Response fields hold stable while rsp_valid_o && !rsp_ready_i.
  - Back-to-back throughput is one request per cycle while rsp_ready_i=1.
- Response state machine:
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept with rsp_ready_i (new response replaces the old).
  - FULL -> EMPTY on rsp_ready_i with no accept.
- Stores:
  - Byte lanes are written on the accept edge: SB lane addr[1:0]; SH lanes {addr[1],0} and +1; SW all four lanes.
  - Data is replicated per lane: SB uses st_data[7:0], SH uses st_data[15:0].
  - Stores to the input region have no effect and rsp_err_o=0.
- Loads:
  - The addressed word is read at the accept edge and registered.
  - LB/LH sign-extend, LBU/LHU zero-extend, LW returns the full word.
  - A load accepted on the edge after a store to the same word returns the stored data.
- Faults:
  - LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0, or any other funct3 value is a fault.
  - On a fault: no write, no flag clear, rsp_err_o=1, ld_data_o=0.
- Input path:
  - Each bit passes through SYNC_STAGES flops.
  - Change flag k sets when the last synchroniser stage differs from its previous value.
  - A non-faulting load of the status word captures the flags and clears them on the accept edge. A change detected on that same edge sets the flag and wins over the clear.
- Reset:
  - rsp_valid_o=0, rsp_err_o=0, ld_data_o=0, all io_out_o=0.
  - Synchroniser flops and previous values = 0; change flags = 0.
  - Data RAM contents are not reset, so the RAM can map to block RAM.
  - Reset asserted mid-transaction drops any pending response. req_ready_o=1 in the first cycle after release.

Test Plan:
- Word store and load, each with rsp_ready_i=1:
  - SW 0x1234_5678 @0x010, then LW @0x010 -> responses on consecutive cycles, second ld_data_o=0x1234_5678, rsp_err_o=0.
- Sub-word stores and extension:
  - SB 0x80 @0x013, then LB @0x013 -> 0xFFFF_FF80.
  - LBU @0x013 -> 0x0000_0080.
  - SH 0xBEEF @0x012, then LHU @0x012 -> 0x0000_BEEF.
- Misaligned access:
  - LW @0x002 -> rsp_err_o=1, ld_data_o=0.
  - SH 0xFFFF @0x011, then LW @0x010 -> word unchanged.
- Output registers:
  - SW 0xA5 @0x804 -> io_out_o channel 1 = 0x0000_00A5.
  - SW @0x800+4*OUT_CH -> no output change, reads back 0.
- Backpressure:
  - Issue LW @0x010, then LW @0x014 with rsp_ready_i=0 for 3 cycles -> req_ready_o=0 after the first accept.
  - Response 1 holds for 3 cycles.
  - Responses arrive in order once rsp_ready_i=1.
- Input sync and flags (IN_CH=2, SYNC_STAGES=2):
  - Drive io_in_i channel 0 = 0x5 -> LW @0x900 returns 0x5 no earlier than 2 cycles later.
  - LW @0x9FC -> 0x1. Repeat LW @0x9FC -> 0x0.
  - Flag change on the clearing edge -> next read of @0x9FC still returns 0x1.
  - Assert rst_ni while rsp_valid_o=1 -> rsp_valid_o=0 immediately, io_out_o=0.
